// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - handshaked single-outstanding data-memory responder with wait states
module dm_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          DEPTH   = 1 << ADDR_WIDTH;
    localparam int          HI      = ADDR_WIDTH + 2;
    // Counter holds the number of pure wait edges still to go before the access edge.
    localparam logic [3:0]  LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;
    logic [3:0]              r_be;
    logic                    r_err;
    logic [31:0]             r_rdata;
    logic                    r_rsp_err;
    logic [31:0]             r_mem [0:DEPTH-1];

    logic                    w_accept;
    logic                    w_access;
    logic                    w_do_write;
    logic                    w_err_in;
    logic [ADDR_WIDTH-1:0]   w_idx_in;

    assign w_accept   = req_valid && req_ready;
    assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_do_write = w_access && r_we && !r_err && reset;
    assign w_err_in   = (req_addr >> HI) != (BASE_ADDR >> HI);
    assign w_idx_in   = req_addr[HI-1:2];

    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_rsp_err;

    // State register; reset aborts any request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; req_ready is forced low while reset is held.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = reset;
                if (w_accept) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request capture, wait counter and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= 32'd0;
            r_be      <= 4'd0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= LAT_CNT;
                r_we    <= req_we;
                r_idx   <= w_idx_in;
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_err   <= w_err_in;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_access) begin
                r_rdata   <= (r_err || r_we) ? 32'd0 : r_mem[r_idx];
                r_rsp_err <= r_err;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rdata   <= 32'd0;
                r_rsp_err <= 1'b0;
            end
        end
    end

    // Word storage: byte-masked store on the access edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - randomized bench for dm_responder against a word-map reference model
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    dm_responder #(.ADDR_WIDTH(10), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dm_responder #(.ADDR_WIDTH(10), .LATENCY(0), .BASE_ADDR(32'h0)) u_dut_l0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // One full request/response on instance s; called and returning at a falling edge.
    task automatic txn(input int s, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold);
        int          lat;
        int          n;
        int          key;
        bit          exp_err;
        bit          exp_known;
        logic [31:0] exp_data;
        lat       = (s == 0) ? 2 : 0;
        exp_err   = (addr >> 12) != 0;
        key       = s * 4096 + int'(addr[11:2]);
        exp_known = 1'b1;
        if (exp_err || we)         exp_data = 32'd0;
        else if (model.exists(key)) exp_data = model[key];
        else begin
            exp_data  = 32'd0;
            exp_known = 1'b0;
        end

        req_valid[s] = 1'b1;
        req_we[s]    = we;
        req_addr[s]  = addr;
        req_wdata[s] = wdata;
        req_be[s]    = be;
        rsp_ready[s] = (hold == 0);
        check_eq("req_ready_idle", 32'(req_ready[s]), 32'd1);
        @(posedge clk);
        #1;
        req_we[s]    = $urandom_range(0, 1);
        req_addr[s]  = $urandom;
        req_wdata[s] = $urandom;
        req_be[s]    = 4'($urandom);

        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rsp_valid[s]) break;
        end
        check_eq("rsp_latency", 32'(n), 32'(lat + 1));
        if (exp_known) check_eq("rsp_rdata", rsp_rdata[s], exp_data);
        check_eq("rsp_err", 32'(rsp_err[s]), 32'(exp_err));
        check_eq("req_ready_busy", 32'(req_ready[s]), 32'd0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid[s]), 32'd1);
            if (exp_known) check_eq("hold_rdata", rsp_rdata[s], exp_data);
            check_eq("hold_req_ready", 32'(req_ready[s]), 32'd0);
        end

        rsp_ready[s] = 1'b1;
        req_valid[s] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rsp_ready[s] = 1'b0;
        check_eq("done_valid", 32'(rsp_valid[s]), 32'd0);
        check_eq("done_req_ready", 32'(req_ready[s]), 32'd1);
        check_eq("done_rdata", rsp_rdata[s], 32'd0);
        check_eq("done_err", 32'(rsp_err[s]), 32'd0);

        if (we && !exp_err) begin
            if (model.exists(key))   model[key] = merge(model[key], wdata, be);
            else if (be == 4'hF)     model[key] = wdata;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          s;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0;
            req_we[i]    = 1'b0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
            req_be[i]    = 4'd0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check_eq("rst_req_ready", 32'(req_ready[i]), 32'd0);
            check_eq("rst_rdata", rsp_rdata[i], 32'd0);
            check_eq("rst_err", 32'(rsp_err[i]), 32'd0);
        end
        reset = 1'b1;
        #1;
        check_eq("rel_req_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 16; w++)
                txn(i, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);

        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
        check_eq("byte_merge", model[4], 32'hDEADBEAA);
        txn(0, 1'b1, 32'h10, 32'h55555555, 4'h0, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
        txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0);
        txn(0, 1'b1, 32'h1010, 32'hFFFFFFFF, 4'hF, 0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);

        // Store accepted, then reset during WAIT: the store must not land.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h20;
        req_wdata[0] = ~model[8];
        req_be[0]    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check_eq("abort_req_ready", 32'(req_ready[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_rsp_valid2", 32'(rsp_valid[0]), 32'd0);
        reset = 1'b1;
        #1;
        check_eq("abort_rel_ready", 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

        txn(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1010, 0);
        txn(1, 1'b0, 32'h30, 32'h0, 4'h0, 2);
        txn(1, 1'b0, 32'h00002000, 32'h0, 4'h0, 0);

        for (int t = 0; t < 80; t++) begin
            s = $urandom_range(0, 1);
            a = {20'd0, 6'd0, 4'($urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 1048575)) << 12);
            txn(s, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
